// File: rtl/ez8_io_pkg.sv
// Shared constants for the ez8 I/O controller: register addresses, IRQ bit
// positions, reset values and the sticky-status update rule.
package ez8_io_pkg;

  localparam logic [4:0] IO_SWITCHES   = 5'h00;
  localparam logic [4:0] IO_KEYS       = 5'h01;
  localparam logic [4:0] IO_LEDS       = 5'h02;
  localparam logic [4:0] IO_IRQ_EN     = 5'h03;
  localparam logic [4:0] IO_IRQ_STATUS = 5'h04;
  localparam logic [4:0] IO_TIMER_CMP  = 5'h05;
  localparam logic [4:0] IO_TIMER_CNT  = 5'h06;
  localparam logic [4:0] IO_TIMER_CTRL = 5'h07;

  localparam int IRQ_KEY0  = 0;
  localparam int IRQ_KEY1  = 1;
  localparam int IRQ_KEY2  = 2;
  localparam int IRQ_KEY3  = 3;
  localparam int IRQ_SW    = 4;
  localparam int IRQ_TIMER = 5;
  localparam int IRQ_BITS  = 6;

  localparam int NUM_KEYS     = 4;
  localparam int NUM_SWITCHES = 4;
  localparam int NUM_LEDS     = 4;

  localparam logic [7:0] TIMER_CMP_RST = 8'hFF;

  // Write-one-to-clear, with a same-cycle set taking priority over the clear.
  function automatic logic [IRQ_BITS-1:0] status_update(
    input logic [IRQ_BITS-1:0] cur,
    input logic [IRQ_BITS-1:0] clr,
    input logic [IRQ_BITS-1:0] set
  );
    return (cur & ~clr) | set;
  endfunction

endpackage

// File: rtl/ez8_io_sync.sv
// Two-flop input synchronizer with an extra "previous" flop so the parent can
// detect edges by comparing sync against prev.
module ez8_io_sync #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] prev
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0] prev_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        meta_reg[gi] <= RESET_VAL[gi];
        sync_reg[gi] <= RESET_VAL[gi];
        prev_reg[gi] <= RESET_VAL[gi];
      end else begin
        meta_reg[gi] <= async_in[gi];
        sync_reg[gi] <= meta_reg[gi];
        prev_reg[gi] <= sync_reg[gi];
      end
    end
  end

  assign sync = sync_reg;
  assign prev = prev_reg;

endmodule

// File: rtl/ez8_io_ctrl.sv
// Memory-mapped I/O block for the ez8 CPU: switches, keys, LEDs, an 8-bit
// interval timer and masked one-cycle interrupt pulses.
module ez8_io_ctrl
  import ez8_io_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] readaddr,
  output logic [7:0] readdata,
  input  logic [4:0] writeaddr,
  input  logic [7:0] writedata,
  input  logic       write_en,
  output logic [7:0] interrupts,
  input  logic [3:0] switches,
  input  logic [3:0] keys,
  output logic [3:0] leds
);

  logic [NUM_KEYS-1:0]     key_sync;
  logic [NUM_KEYS-1:0]     key_prev;
  logic [NUM_SWITCHES-1:0] sw_sync;
  logic [NUM_SWITCHES-1:0] sw_prev;

  logic [NUM_LEDS-1:0] leds_reg,       leds_next;
  logic [IRQ_BITS-1:0] irq_en_reg,     irq_en_next;
  logic [IRQ_BITS-1:0] irq_status_reg, irq_status_next;
  logic [7:0]          timer_cmp_reg,  timer_cmp_next;
  logic [7:0]          timer_cnt_reg,  timer_cnt_next;
  logic                timer_en_reg,   timer_en_next;

  logic [7:0]          events;
  logic                timer_match;
  logic [IRQ_BITS-1:0] status_clr;

  logic wr_leds;
  logic wr_irq_en;
  logic wr_irq_status;
  logic wr_timer_cmp;
  logic wr_timer_cnt;
  logic wr_timer_ctrl;

  // Keys are active-low, so the idle (released) state is all ones.
  ez8_io_sync #(
    .WIDTH    (NUM_KEYS),
    .RESET_VAL({NUM_KEYS{1'b1}})
  ) u_key_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(keys),
    .sync    (key_sync),
    .prev    (key_prev)
  );

  ez8_io_sync #(
    .WIDTH    (NUM_SWITCHES),
    .RESET_VAL({NUM_SWITCHES{1'b0}})
  ) u_sw_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(switches),
    .sync    (sw_sync),
    .prev    (sw_prev)
  );

  assign wr_leds       = write_en && (writeaddr == IO_LEDS);
  assign wr_irq_en     = write_en && (writeaddr == IO_IRQ_EN);
  assign wr_irq_status = write_en && (writeaddr == IO_IRQ_STATUS);
  assign wr_timer_cmp  = write_en && (writeaddr == IO_TIMER_CMP);
  assign wr_timer_cnt  = write_en && (writeaddr == IO_TIMER_CNT);
  assign wr_timer_ctrl = write_en && (writeaddr == IO_TIMER_CTRL);

  assign timer_match = timer_en_reg && (timer_cnt_reg == timer_cmp_reg);

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key_evt
    assign events[IRQ_KEY0 + gi] = key_prev[gi] & ~key_sync[gi];
  end
  assign events[IRQ_SW]    = |(sw_sync ^ sw_prev);
  assign events[IRQ_TIMER] = timer_match;
  assign events[7:6]       = 2'b00;

  assign interrupts = events & {2'b00, irq_en_reg};
  assign leds       = leds_reg;

  assign status_clr = wr_irq_status ? writedata[IRQ_BITS-1:0] : '0;

  always_comb begin
    leds_next       = leds_reg;
    irq_en_next     = irq_en_reg;
    timer_cmp_next  = timer_cmp_reg;
    timer_en_next   = timer_en_reg;
    irq_status_next = status_update(irq_status_reg, status_clr, events[IRQ_BITS-1:0]);

    if (wr_leds)       leds_next      = writedata[NUM_LEDS-1:0];
    if (wr_irq_en)     irq_en_next    = writedata[IRQ_BITS-1:0];
    if (wr_timer_cmp)  timer_cmp_next = writedata;
    if (wr_timer_ctrl) timer_en_next  = writedata[0];
  end

  // A CNT write outranks both the match wrap and the increment.
  always_comb begin
    timer_cnt_next = timer_cnt_reg;
    if (wr_timer_cnt) begin
      timer_cnt_next = 8'h00;
    end else if (timer_en_reg) begin
      timer_cnt_next = timer_match ? 8'h00 : timer_cnt_reg + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_reg       <= '0;
      irq_en_reg     <= '0;
      irq_status_reg <= '0;
      timer_cmp_reg  <= TIMER_CMP_RST;
      timer_cnt_reg  <= 8'h00;
      timer_en_reg   <= 1'b0;
    end else begin
      leds_reg       <= leds_next;
      irq_en_reg     <= irq_en_next;
      irq_status_reg <= irq_status_next;
      timer_cmp_reg  <= timer_cmp_next;
      timer_cnt_reg  <= timer_cnt_next;
      timer_en_reg   <= timer_en_next;
    end
  end

  always_comb begin
    readdata = 8'h00;
    case (readaddr)
      IO_SWITCHES:   readdata = {4'b0000, sw_sync};
      IO_KEYS:       readdata = {4'b0000, ~key_sync};
      IO_LEDS:       readdata = {4'b0000, leds_reg};
      IO_IRQ_EN:     readdata = {2'b00, irq_en_reg};
      IO_IRQ_STATUS: readdata = {2'b00, irq_status_reg};
      IO_TIMER_CMP:  readdata = timer_cmp_reg;
      IO_TIMER_CNT:  readdata = timer_cnt_reg;
      IO_TIMER_CTRL: readdata = {7'b0000000, timer_en_reg};
      default:       readdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ez8_io_ctrl.sv
// Directed bench for ez8_io_ctrl: register access, key/switch events, timer
// match cadence, W1C priority and asynchronous reset.
module tb_ez8_io_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] readaddr;
  logic [7:0] readdata;
  logic [4:0] writeaddr;
  logic [7:0] writedata;
  logic       write_en;
  logic [7:0] interrupts;
  logic [3:0] switches;
  logic [3:0] keys;
  logic [3:0] leds;

  int pass_cnt  = 0;
  int check_cnt = 0;

  ez8_io_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .readaddr  (readaddr),
    .readdata  (readdata),
    .writeaddr (writeaddr),
    .writedata (writedata),
    .write_en  (write_en),
    .interrupts(interrupts),
    .switches  (switches),
    .keys      (keys),
    .leds      (leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    $display("check %-14s observed %02h expected %02h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [4:0] addr, input logic [7:0] data);
    writeaddr = addr;
    writedata = data;
    write_en  = 1'b1;
    tick();
    write_en  = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [4:0] addr, input logic [7:0] exp);
    readaddr = addr;
    #1;
    check(tag, readdata, exp);
  endtask

  logic [4:0] rst_addr [9];
  logic [7:0] rst_exp  [9];

  initial begin
    rst_addr = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h1F};
    rst_exp  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};

    reset     = 1'b0;
    readaddr  = 5'h00;
    writeaddr = 5'h00;
    writedata = 8'h00;
    write_en  = 1'b0;
    switches  = 4'h0;
    keys      = 4'hF;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Reset values
    for (int i = 0; i < 9; i++) check_read($sformatf("rst_rd_%02h", rst_addr[i]), rst_addr[i], rst_exp[i]);
    check("rst_leds", {4'h0, leds}, 8'h00);
    check("rst_irq", interrupts, 8'h00);

    // LEDs: write/readback, masking, same-cycle read returns old value
    io_write(5'h02, 8'h0A);
    check_read("leds_rd", 5'h02, 8'h0A);
    check("leds_out", {4'h0, leds}, 8'h0A);
    writeaddr = 5'h02;
    writedata = 8'hFF;
    write_en  = 1'b1;
    readaddr  = 5'h02;
    #1;
    check("leds_rd_old", readdata, 8'h0A);
    tick();
    write_en = 1'b0;
    check_read("leds_rd_mask", 5'h02, 8'h0F);

    // Unmapped write ignored
    io_write(5'h10, 8'hAA);
    check_read("unmapped_rd", 5'h10, 8'h00);
    check_read("leds_keep", 5'h02, 8'h0F);

    // Key 0 press: pulse after the second sampling edge, exactly one cycle
    io_write(5'h03, 8'h01);
    keys = 4'hE;
    tick();
    check("key_irq_k", interrupts, 8'h00);
    tick();
    check("key_irq_k1", interrupts, 8'h01);
    check_read("keys_rd", 5'h01, 8'h01);
    tick();
    check("key_irq_k2", interrupts, 8'h00);
    check_read("key_status", 5'h04, 8'h01);
    io_write(5'h04, 8'h01);
    check_read("key_status_clr", 5'h04, 8'h00);
    keys = 4'hF;
    repeat (4) begin
      tick();
      check("key_release", interrupts, 8'h00);
    end
    check_read("rel_status", 5'h04, 8'h00);

    // Switch change with IRQ masked: status bit 4 set, no pulse
    io_write(5'h03, 8'h00);
    switches = 4'h5;
    repeat (4) begin
      tick();
      check("sw_no_irq", interrupts, 8'h00);
    end
    check_read("sw_status", 5'h04, 8'h10);
    check_read("sw_rd", 5'h00, 8'h05);
    io_write(5'h04, 8'hFF);
    check_read("sw_status_clr", 5'h04, 8'h00);

    // Timer CMP=3: count 0,1,2,3 repeating, pulse at 3
    io_write(5'h05, 8'h03);
    io_write(5'h03, 8'h20);
    check_read("cmp_rd", 5'h05, 8'h03);
    io_write(5'h07, 8'h01);
    check_read("ctrl_rd", 5'h07, 8'h01);
    readaddr = 5'h06;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("tmr_cnt_%0d", i), readdata, 8'((i % 4)));
      check($sformatf("tmr_irq_%0d", i), interrupts, (i % 4 == 3) ? 8'h20 : 8'h00);
      tick();
    end
    check_read("tmr_cnt_8", 5'h06, 8'h00);
    tick();
    check_read("tmr_cnt_9", 5'h06, 8'h01);
    io_write(5'h06, 8'h55);
    check_read("tmr_restart", 5'h06, 8'h00);
    tick();
    check_read("tmr_after_rs", 5'h06, 8'h01);

    // Same-cycle timer match and W1C of bit 5: set wins
    io_write(5'h04, 8'h20);
    check_read("w1c_status", 5'h04, 8'h00);
    check_read("w1c_cnt", 5'h06, 8'h02);
    tick();
    check("match_irq", interrupts, 8'h20);
    io_write(5'h04, 8'h20);
    check_read("set_wins", 5'h04, 8'h20);
    check_read("wrap_cnt", 5'h06, 8'h00);

    // Asynchronous reset mid-operation
    #2;
    reset = 1'b0;
    #1;
    check("arst_leds", {4'h0, leds}, 8'h00);
    check("arst_irq", interrupts, 8'h00);
    check_read("arst_cmp", 5'h05, 8'hFF);
    check_read("arst_sw", 5'h00, 8'h00);
    check_read("arst_ctrl", 5'h07, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_irq", interrupts, 8'h00);
    check_read("post_rst_cnt", 5'h06, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/ez8_io_ctrl.md
# ez8_io_ctrl

Memory-mapped I/O controller for the ez8 CPU. It connects the CPU's 5-bit I/O read/write ports to board switches, push-keys and LEDs, and adds an 8-bit interval timer. It raises per-source interrupt pulses on `interrupts[7:0]`, which the CPU samples.

## Interface
- No parameters; all widths are fixed.
- `clk` in 1: single system clock. All flops are rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `readaddr` in 5: I/O read address.
- `readdata` out 8: read data. Combinational from `readaddr`.
- `writeaddr` in 5: I/O write address.
- `writedata` in 8: write data.
- `write_en` in 1: write strobe, sampled at `clk` rise.
- `interrupts` out 8: one-cycle event pulses, already masked by IRQ_EN.
- `switches` in 4: asynchronous level inputs.
- `keys` in 4: asynchronous inputs, active-low (0 = pressed).
- `leds` out 4: LED drive, equal to LEDS[3:0].

## Operation

Register map. Unlisted addresses (0x08–0x1F) read 0x00; writes to them are ignored.
- 0x00 SWITCHES, RO: {4'b0, sw_s}.
- 0x01 KEYS, RO: {4'b0, ~key_s}; 1 = pressed.
- 0x02 LEDS, RW: bits [3:0] are stored; [7:4] read 0.
- 0x03 IRQ_EN, RW: bits [5:0] are stored; [7:6] read 0.
- 0x04 IRQ_STATUS: sticky event bits [5:0].
  - Writing a 1 clears that bit; writing a 0 leaves it unchanged.
  - Bits [7:6] read 0.
- 0x05 TIMER_CMP, RW: 8-bit compare value.
- 0x06 TIMER_CNT: reads the counter. Any write loads 0.
- 0x07 TIMER_CTRL, RW: bit0 = enable; other bits read 0.

Input synchronisation:
- `switches` and `keys` each pass through a 2-flop synchronizer, giving `sw_s` and `key_s`.
- A third "previous" flop per bit is used for edge detection.

Events (bit index):
- Bits 0–3: falling edge of `key_s[i]`, i.e. a key press.
- Bit 4: any bit of `sw_s` changed.
- Bit 5: timer match. When enabled and CNT == CMP, CNT wraps to 0 on the next edge instead of incrementing.
- Bits 7:6: always 0.

Interrupt and status behaviour:
- `interrupts[i]` = event[i] & IRQ_EN[i]. It is combinational and lasts one cycle per event.
- IRQ_STATUS[i] is set on event[i] whether or not bit i is enabled.
- If a set and a W1C hit the same bit in the same cycle, the set wins.

Timer:
- When enabled, the 8-bit counter increments each cycle. It wraps to 0 after a match, or naturally at 0xFF when CMP is 0xFF.
- A write to TIMER_CNT beats the increment in the same cycle.
- When disabled, the count holds.

## Timing

Reset values:
- All outputs are 0 (`readdata` follows its reset registers).
- LEDS, IRQ_EN, IRQ_STATUS, TIMER_CNT and TIMER_CTRL reset to 0.
- TIMER_CMP resets to 0xFF.
- Key synchronizer flops reset to 1 (released); switch synchronizer flops reset to 0.

Latency:
- Input edge sampled at edge k → stage 2 updates at k+1 → SWITCHES/KEYS readback and the event/`interrupts` pulse appear in the cycle after k+1.
- IRQ_STATUS is set at edge k+2.

Writes:
- A write takes effect at the `clk` edge where `write_en` = 1.
- A read of the same address in the next cycle returns the new value.
- A read and a write in the same cycle return the old value.

Timer match: with CMP = N and the counter enabled from 0, the match pulse occurs every N+1 cycles.

Reset asserted mid-operation: all state clears immediately and no pulse is emitted.

## Structure
- Package `ez8_io_pkg` holds:
  - the address localparams (`IO_SWITCHES` … `IO_TIMER_CTRL`);
  - the IRQ bit indices (`IRQ_KEY0`–`IRQ_KEY3`, `IRQ_SW`, `IRQ_TIMER`).
- One sub-module, `ez8_io_sync`: a parameterised-width 2-flop synchronizer plus previous-value flop, with outputs `sync` and `prev`. It is instantiated once for keys and once for switches.
- The register file, timer and read mux live in the top module.

## Test plan
1. Reset, then read 0x00–0x07 and 0x1F → 00,00,00,00,00,FF,00,00,00. `leds` = 0 and `interrupts` = 0.
2. Write 0x0A to 0x02, then read 0x02 → `leds` = 4'hA and readdata = 0x0A. Write 0xFF to 0x02 → read 0x0F.
3. Write IRQ_EN = 0x01, then drive `keys[0]` 1→0 → exactly one `interrupts[0]` pulse, 2 cycles after sampling. IRQ_STATUS reads 0x01. Write 0x01 to 0x04 → status reads 0x00. Releasing the key gives no event.
4. Set `switches` to 4'h5 with IRQ_EN = 0 → no `interrupts`, but IRQ_STATUS bit 4 is set and 0x00 reads 0x05.
5. Write CMP = 3, CTRL = 1, IRQ_EN = 0x20 → `interrupts[5]` pulses every 4 cycles and the counter sequence is 0,1,2,3,0. Writing to 0x06 mid-count restarts at 0.
6. Same-cycle timer event and W1C of bit 5 → bit 5 remains 1.
